// File: rtl/npc_rf_pkg.sv
// ============================================================================
// Module : npc_rf_pkg
// Shared widths, requester select encoding and x0 index for the RF writeback
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package npc_rf_pkg;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;
  localparam int X0_IDX        = 0;

  typedef enum logic {
    REQ_EXU = 1'b0,
    REQ_LSU = 1'b1
  } req_sel_e;
endpackage

`default_nettype wire

// File: rtl/rf_wb_scoreboard_rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Two-requester round-robin arbiter, one-hot grant, pointer flips after grant
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import npc_rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_sel_e r_ptr;

  // Grants are suppressed while reset is held so nothing is accepted then.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (&req) begin
        gnt = (r_ptr == REQ_EXU) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= REQ_EXU;
    end else if (gnt[0]) begin
      r_ptr <= REQ_LSU;
    end else if (gnt[1]) begin
      r_ptr <= REQ_EXU;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rf_wb_scoreboard.sv
// ============================================================================
// Module : rf_wb_scoreboard
// EXU/LSU writeback arbitration onto one RF write port plus busy scoreboard
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_wb_scoreboard
  import npc_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iss_valid,
  input  logic [ADDR_WIDTH-1:0]    iss_rd,
  input  logic                     iss_rd_en,
  input  logic [ADDR_WIDTH-1:0]    iss_rs1,
  input  logic [ADDR_WIDTH-1:0]    iss_rs2,
  output logic                     iss_stall,
  input  logic                     exu_valid,
  output logic                     exu_ready,
  input  logic [ADDR_WIDTH-1:0]    exu_rd,
  input  logic [DATA_WIDTH-1:0]    exu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [ADDR_WIDTH-1:0]    lsu_rd,
  input  logic [DATA_WIDTH-1:0]    lsu_data,
  output logic                     rf_wen,
  output logic [ADDR_WIDTH-1:0]    rf_waddr,
  output logic [DATA_WIDTH-1:0]    rf_wdata,
  output logic [2**ADDR_WIDTH-1:0] busy_vec,
  output logic                     wb_err
);

  localparam int NREG = 2**ADDR_WIDTH;

  logic [1:0]            w_gnt;
  logic                  w_gnt_wr;
  logic [ADDR_WIDTH-1:0] w_gnt_rd;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic                  w_iss_acc;
  logic [NREG-1:0]       w_busy_nxt;

  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NREG-1:0]       r_busy;
  logic                  r_err;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({lsu_valid, exu_valid}),
    .gnt (w_gnt)
  );

  assign exu_ready  = w_gnt[0];
  assign lsu_ready  = w_gnt[1];
  assign w_gnt_rd   = w_gnt[1] ? lsu_rd   : exu_rd;
  assign w_gnt_data = w_gnt[1] ? lsu_data : exu_data;
  // An x0 writeback is accepted but never reaches the register file.
  assign w_gnt_wr   = (|w_gnt) && (w_gnt_rd != ADDR_WIDTH'(X0_IDX));

  // busy[0] is held at zero, so x0 sources never stall.
  assign iss_stall = iss_valid &&
                     (r_busy[iss_rs1] || r_busy[iss_rs2] ||
                      (iss_rd_en && r_busy[iss_rd]));
  assign w_iss_acc = iss_valid && !iss_stall;

  // Clear first, then set, so a same-index set wins over the retiring write.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wen) begin
      w_busy_nxt[r_waddr] = 1'b0;
    end
    if (w_iss_acc && iss_rd_en) begin
      w_busy_nxt[iss_rd] = 1'b1;
    end
    w_busy_nxt[X0_IDX] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_busy  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_wen  <= w_gnt_wr;
      r_busy <= w_busy_nxt;
      if (w_gnt_wr) begin
        r_waddr <= w_gnt_rd;
        r_wdata <= w_gnt_data;
        if (!r_busy[w_gnt_rd]) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign rf_wen   = r_wen;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign busy_vec = r_busy;
  assign wb_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_scoreboard.sv
// ============================================================================
// Module : tb_rf_wb_scoreboard
// Directed vector table, reset corner sequence and randomized reference check
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rf_wb_scoreboard;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_rd_en;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rs2;
  logic        iss_stall;
  logic        exu_valid;
  logic        exu_ready;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_vec;
  logic        wb_err;

  int n_chk;
  int n_pass;

  rf_wb_scoreboard #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_rd_en (iss_rd_en),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_stall (iss_stall),
    .exu_valid (exu_valid),
    .exu_ready (exu_ready),
    .exu_rd    (exu_rd),
    .exu_data  (exu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy_vec  (busy_vec),
    .wb_err    (wb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        iv;
    logic [4:0]  ird;
    logic        iren;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ev;
    logic [4:0]  erd;
    logic [31:0] ed;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        x_stall;
    logic        x_er;
    logic        x_lr;
    logic        x_wen;
    logic [4:0]  x_waddr;
    logic [31:0] x_wdata;
    logic [31:0] x_busy;
    logic        x_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input vec_t t);
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic r, input logic iv, input logic [4:0] ird, input logic iren,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    rst = r; iss_valid = iv; iss_rd = ird; iss_rd_en = iren; iss_rs1 = rs1; iss_rs2 = rs2;
    exu_valid = ev; exu_rd = erd; exu_data = ed;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state, advanced once per clock from the rules alone.
  logic [31:0] m_busy;
  int          m_ptr;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        m_err;

  function automatic bit bz(input logic [4:0] r);
    return (r != 0) && m_busy[r];
  endfunction

  initial begin
    vec_t t;
    bit e_v, l_v, do_rst, x_stall;
    logic [4:0] e_rd, l_rd, g_rd;
    logic [31:0] e_d, l_d, g_d, nb;
    int g;
    n_chk = 0;
    n_pass = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // rst iv ird en rs1 rs2 | ev erd ed | lv lrd ld | stall er lr wen waddr wdata busy err
    t = '{1,0,0,0,0,0, 1,5,32'h5,        0,0,0,           0,0,0,0,0,0,32'h0,0};            add(t);
    t = '{0,1,3,1,0,0, 0,0,0,            0,0,0,           0,0,0,0,0,0,32'h0,0};            add(t);
    t = '{0,0,0,0,0,0, 1,3,32'hDEADBEEF, 0,0,0,           0,1,0,0,0,0,32'h8,0};            add(t);
    t = '{0,0,0,0,0,0, 0,0,0,            0,0,0,           0,0,0,1,3,32'hDEADBEEF,32'h8,0}; add(t);
    t = '{0,0,0,0,0,0, 0,0,0,            0,0,0,           0,0,0,0,0,0,32'h0,0};            add(t);
    t = '{1,0,0,0,0,0, 0,0,0,            0,0,0,           0,0,0,0,0,0,32'h0,0};            add(t);
    t = '{0,1,1,1,0,0, 0,0,0,            0,0,0,           0,0,0,0,0,0,32'h0,0};            add(t);
    t = '{0,1,2,1,0,0, 0,0,0,            0,0,0,           0,0,0,0,0,0,32'h2,0};            add(t);
    t = '{0,0,0,0,0,0, 1,1,32'h11111111, 1,2,32'h22222222, 0,1,0,0,0,0,32'h6,0};           add(t);
    t = '{0,0,0,0,0,0, 1,2,32'h33333333, 1,2,32'h22222222, 0,0,1,1,1,32'h11111111,32'h6,0}; add(t);
    t = '{0,0,0,0,0,0, 1,2,32'h33333333, 0,0,0,           0,1,0,1,2,32'h22222222,32'h4,0}; add(t);
    t = '{0,0,0,0,0,0, 0,0,0,            0,0,0,           0,0,0,1,2,32'h33333333,32'h0,0}; add(t);
    t = '{0,0,0,0,0,0, 0,0,0,            0,0,0,           0,0,0,0,0,0,32'h0,0};            add(t);
    t = '{0,1,7,1,0,0, 0,0,0,            0,0,0,           0,0,0,0,0,0,32'h0,0};            add(t);
    t = '{0,1,8,1,7,0, 0,0,0,            0,0,0,           1,0,0,0,0,0,32'h80,0};           add(t);
    t = '{0,1,8,1,7,0, 0,0,0,            1,7,32'h77,      1,0,1,0,0,0,32'h80,0};           add(t);
    t = '{0,1,8,1,7,0, 0,0,0,            0,0,0,           1,0,0,1,7,32'h77,32'h80,0};      add(t);
    t = '{0,1,8,1,7,0, 0,0,0,            0,0,0,           0,0,0,0,0,0,32'h0,0};            add(t);
    t = '{0,0,0,0,0,0, 0,0,0,            0,0,0,           0,0,0,0,0,0,32'h100,0};          add(t);
    t = '{0,0,0,0,0,0, 0,0,0,            1,0,32'h55,      0,0,1,0,0,0,32'h100,0};          add(t);
    t = '{0,0,0,0,0,0, 0,0,0,            0,0,0,           0,0,0,0,0,0,32'h100,0};          add(t);
    t = '{0,0,0,0,0,0, 1,9,32'h99,       0,0,0,           0,1,0,0,0,0,32'h100,0};          add(t);
    t = '{0,0,0,0,0,0, 1,4,32'h44,       0,0,0,           0,1,0,1,9,32'h99,32'h100,1};     add(t);
    t = '{0,1,4,1,0,0, 0,0,0,            0,0,0,           0,0,0,1,4,32'h44,32'h100,1};     add(t);
    t = '{0,0,0,0,0,0, 0,0,0,            0,0,0,           0,0,0,0,0,0,32'h110,1};          add(t);
    t = '{1,0,0,0,0,0, 0,0,0,            0,0,0,           0,0,0,0,0,0,32'h0,0};            add(t);

    tick();
    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      drive(t.rst, t.iv, t.ird, t.iren, t.rs1, t.rs2, t.ev, t.erd, t.ed, t.lv, t.lrd, t.ld);
      #1;
      chk($sformatf("row%0d iss_stall", i), iss_stall, t.x_stall);
      chk($sformatf("row%0d exu_ready", i), exu_ready, t.x_er);
      chk($sformatf("row%0d lsu_ready", i), lsu_ready, t.x_lr);
      chk($sformatf("row%0d rf_wen", i), rf_wen, t.x_wen);
      chk($sformatf("row%0d busy_vec", i), busy_vec, t.x_busy);
      chk($sformatf("row%0d wb_err", i), wb_err, t.x_err);
      if (t.x_wen || t.rst) begin
        chk($sformatf("row%0d rf_waddr", i), rf_waddr, t.x_waddr);
        chk($sformatf("row%0d rf_wdata", i), rf_wdata, t.x_wdata);
      end
      tick();
    end

    // Reset landing on a pending write: the write must vanish at once.
    drive(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 5, 32'h5555, 0, 0, 0);
    #1;
    chk("mid grant exu_ready", exu_ready, 1'b1);
    tick();
    chk("mid wen before rst", rf_wen, 1'b1);
    chk("mid busy before rst", busy_vec, 32'h20);
    exu_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid rst rf_wen", rf_wen, 1'b0);
    chk("mid rst busy_vec", busy_vec, 32'h0);
    chk("mid rst wb_err", wb_err, 1'b0);
    // A grant raised while reset is held is refused.
    exu_valid = 1'b1;
    #1;
    chk("mid rst exu_ready", exu_ready, 1'b0);
    tick();
    chk("mid rst no write", rf_wen, 1'b0);

    // Randomized traffic against the rule-level model.
    e_v = 0; l_v = 0; e_rd = 0; l_rd = 0; e_d = 0; l_d = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      do_rst = (cyc == 0) || ($urandom % 97 == 0);
      if (do_rst) begin
        e_v = 0; l_v = 0;
      end else begin
        if (!e_v && ($urandom % 3 == 0)) begin e_v = 1; e_rd = 5'($urandom_range(0, 7)); e_d = $urandom; end
        if (!l_v && ($urandom % 3 == 0)) begin l_v = 1; l_rd = 5'($urandom_range(0, 7)); l_d = $urandom; end
      end
      drive(do_rst, 1'($urandom % 2), 5'($urandom_range(0, 7)), ($urandom % 4) != 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), e_v, e_rd, e_d, l_v, l_rd, l_d);
      #1;
      if (do_rst) begin
        m_busy = 0; m_ptr = 0; m_wen = 0; m_waddr = 0; m_wdata = 0; m_err = 0;
      end
      if (do_rst)          g = -1;
      else if (e_v && l_v) g = m_ptr;
      else if (e_v)        g = 0;
      else if (l_v)        g = 1;
      else                 g = -1;
      x_stall = iss_valid && (bz(iss_rs1) || bz(iss_rs2) || (iss_rd_en && bz(iss_rd)));

      chk($sformatf("rnd%0d iss_stall", cyc), iss_stall, x_stall);
      chk($sformatf("rnd%0d exu_ready", cyc), exu_ready, g == 0);
      chk($sformatf("rnd%0d lsu_ready", cyc), lsu_ready, g == 1);
      chk($sformatf("rnd%0d rf_wen", cyc), rf_wen, m_wen);
      chk($sformatf("rnd%0d busy_vec", cyc), busy_vec, m_busy);
      chk($sformatf("rnd%0d wb_err", cyc), wb_err, m_err);
      if (m_wen) begin
        chk($sformatf("rnd%0d rf_waddr", cyc), rf_waddr, m_waddr);
        chk($sformatf("rnd%0d rf_wdata", cyc), rf_wdata, m_wdata);
      end

      if (!do_rst) begin
        nb = m_busy;
        if (m_wen) nb[m_waddr] = 1'b0;
        if (iss_valid && !x_stall && iss_rd_en && iss_rd != 0) nb[iss_rd] = 1'b1;
        m_wen = 0;
        if (g >= 0) begin
          g_rd = (g == 0) ? e_rd : l_rd;
          g_d  = (g == 0) ? e_d  : l_d;
          if (g_rd != 0) begin
            if (!m_busy[g_rd]) m_err = 1;
            m_wen = 1; m_waddr = g_rd; m_wdata = g_d;
          end
          m_ptr = 1 - g;
          if (g == 0) e_v = 0; else l_v = 0;
        end
        m_busy = nb;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
